mc_ctrl_fsm: RTL and testbench

Multi-cycle main control unit for the MIPS datapath. Holds the instruction-phase state machine and, from the state plus the IR-held opcode/funct, drives the ALU operation code, the ALU operand selects, and all PC/memory/IR/register-file enables. It sits directly upstream of the ALU, and the ALU `Zero` flag returns to it to resolve branches in the same cycle.

---
 rtl/mc_ctrl_fsm_pkg.sv | 121 ++++++++++++
 rtl/mc_ctrl_fsm_alu_op_decode.sv | 63 ++++++
 rtl/mc_ctrl_fsm.sv | 165 ++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, ALU codes,
// opcode/funct constants and datapath select values.
package mc_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEM_ADR = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WB  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_R_EX    = 4'd7,
        S_R_WB    = 4'd8,
        S_I_EX    = 4'd9,
        S_I_WB    = 4'd10,
        S_BR      = 4'd11,
        S_JMP     = 4'd12,
        S_JAL     = 4'd13,
        S_JR      = 4'd14
    } state_e;

    // Which flavour of ALU work the current state needs.
    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_PC_ADD = 3'd1,
        CLS_ADDR   = 3'd2,
        CLS_BR     = 3'd3,
        CLS_R      = 3'd4,
        CLS_I      = 3'd5
    } alu_cls_e;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_ADDU = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SUBU = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SLL  = 4'd10;
    localparam logic [3:0] ALU_SRL  = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] SA_PC    = 2'd0;
    localparam logic [1:0] SA_REG   = 2'd1;
    localparam logic [1:0] SA_SHAMT = 2'd2;

    localparam logic [1:0] SB_REG     = 2'd0;
    localparam logic [1:0] SB_FOUR    = 2'd1;
    localparam logic [1:0] SB_IMM     = 2'd2;
    localparam logic [1:0] SB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_REGA   = 2'd3;

    // State following DECODE; S_FETCH marks an unsupported encoding.
    function automatic state_e decode_dispatch(input logic [5:0] op, input logic [5:0] fn);
        state_e nxt;
        nxt = S_FETCH;
        case (op)
            OP_LW, OP_SW: nxt = S_MEM_ADR;
            OP_RTYPE: begin
                case (fn)
                    F_JR: nxt = S_JR;
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_NOR,
                    F_SLT, F_SLTU, F_SLL, F_SRL, F_SLLV, F_SRLV: nxt = S_R_EX;
                    default: nxt = S_FETCH;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: nxt = S_I_EX;
            OP_BEQ, OP_BNE: nxt = S_BR;
            OP_J:   nxt = S_JMP;
            OP_JAL: nxt = S_JAL;
            default: nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_op_decode.sv
// Combinational ALU operation / extension decode from state class and opcode/funct.
// Kept free of FSM state so a pipelined decoder can reuse it.
module mc_ctrl_fsm_alu_op_decode
    import mc_ctrl_fsm_pkg::*;
(
    input  alu_cls_e   cls,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       ext_op
);

    always_comb begin
        alu_op = ALU_NOP;
        ext_op = 1'b0;
        case (cls)
            CLS_PC_ADD: alu_op = ALU_ADD;
            CLS_ADDR: begin
                alu_op = ALU_ADD;
                ext_op = 1'b1;
            end
            CLS_BR: alu_op = ALU_SUB;
            CLS_R: begin
                case (funct)
                    F_ADD:          alu_op = ALU_ADD;
                    F_ADDU:         alu_op = ALU_ADDU;
                    F_SUB:          alu_op = ALU_SUB;
                    F_SUBU:         alu_op = ALU_SUBU;
                    F_AND:          alu_op = ALU_AND;
                    F_OR:           alu_op = ALU_OR;
                    F_NOR:          alu_op = ALU_NOR;
                    F_SLT:          alu_op = ALU_SLT;
                    F_SLTU:         alu_op = ALU_SLTU;
                    F_SLL, F_SLLV:  alu_op = ALU_SLL;
                    F_SRL, F_SRLV:  alu_op = ALU_SRL;
                    default:        alu_op = ALU_NOP;
                endcase
            end
            CLS_I: begin
                case (opcode)
                    OP_ADDI: begin
                        alu_op = ALU_ADD;
                        ext_op = 1'b1;
                    end
                    OP_ADDIU: begin
                        alu_op = ALU_ADDU;
                        ext_op = 1'b1;
                    end
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_SLTI: begin
                        alu_op = ALU_SLT;
                        ext_op = 1'b1;
                    end
                    OP_LUI:  alu_op = ALU_LUI;
                    default: alu_op = ALU_NOP;
                endcase
            end
            default: alu_op = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control: instruction-phase FSM with combinational
// Moore/Mealy output decode (branch pc_en follows the ALU zero flag directly).
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic [3:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_e   state_q, state_d;
    alu_cls_e alu_cls;
    logic     pc_write;
    logic     branch;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_RST;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        alu_cls    = CLS_NONE;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALUOUT;
        alu_src_a  = SA_PC;
        alu_src_b  = SB_REG;
        pc_source  = PCS_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SB_FOUR;
                alu_cls   = CLS_PC_ADD;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                alu_src_b = SB_IMM_SH2;
                alu_cls   = CLS_ADDR;
                state_d   = decode_dispatch(opcode, funct);
                if (state_d == S_FETCH) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEM_ADR: begin
                alu_src_a = SA_REG;
                alu_src_b = SB_IMM;
                alu_cls   = CLS_ADDR;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_R_EX: begin
                alu_src_a = (funct == F_SLL || funct == F_SRL) ? SA_SHAMT : SA_REG;
                alu_cls   = CLS_R;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = RD_RD;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_I_EX: begin
                alu_src_a = SA_REG;
                alu_src_b = SB_IMM;
                alu_cls   = CLS_I;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BR: begin
                alu_src_a  = SA_REG;
                alu_cls    = CLS_BR;
                pc_source  = PCS_ALUOUT;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JMP: begin
                pc_write   = 1'b1;
                pc_source  = PCS_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = PCS_JUMP;
                reg_write  = 1'b1;
                reg_dst    = RD_RA;
                mem_to_reg = M2R_PC;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JR: begin
                pc_write   = 1'b1;
                pc_source  = PCS_REGA;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_RST;
        endcase
    end

    mc_ctrl_fsm_alu_op_decode u_alu_dec (
        .cls    (alu_cls),
        .opcode (opcode),
        .funct  (funct),
        .alu_op (alu_op),
        .ext_op (ext_op)
    );

    assign pc_en = pc_write | (branch & (zero ^ (opcode == OP_BNE)));
    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized scoreboard bench for mc_ctrl_fsm: an instruction-level model
// predicts every cycle's control bundle; a negedge monitor compares.
module tb_mc_ctrl_fsm;
    import mc_ctrl_fsm_pkg::*;

    logic       clk, rstn, zero;
    logic [5:0] opcode, funct;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source;
    logic       ext_op, instr_done, illegal;
    logic [3:0] alu_op, state;

    mc_ctrl_fsm dut (
        .clk(clk), .rstn(rstn), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_op(ext_op), .alu_op(alu_op), .pc_source(pc_source),
        .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en,iord,mr,mw,irw,rw,reg_dst,m2r,src_a,src_b,ext,alu_op,pc_src,done,ill}
    logic [22:0] act;
    assign act = {pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op, pc_source,
                  instr_done, illegal};

    typedef struct {
        logic [22:0] v;
        logic [5:0]  op;
        logic [5:0]  fn;
        int          k;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    typedef enum {K_LW, K_SW, K_R, K_JR, K_I, K_BR, K_J, K_JAL, K_ILL} kind_e;

    function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h00: begin
                if (fn == 6'h08) return K_JR;
                if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27,
                               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h04, 6'h06}) return K_R;
                return K_ILL;
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return K_I;
            6'h04, 6'h05: return K_BR;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int cpi(input kind_e kd);
        case (kd)
            K_LW: return 5;
            K_SW, K_R, K_I: return 4;
            K_ILL: return 2;
            default: return 3;
        endcase
    endfunction

    // Expected control bundle for cycle k (0 = FETCH) of an instruction.
    function automatic logic [22:0] exp_vec(input logic [5:0] op, input logic [5:0] fn,
                                            input logic z, input int k);
        logic pcen, io, mr, mw, irw, rw, ext, dn, il;
        logic [1:0] rd, m2r, sa, sbs, pcs;
        logic [3:0] alu;
        kind_e kd;
        kd = classify(op, fn);
        {pcen, io, mr, mw, irw, rw, ext, dn, il} = '0;
        {rd, m2r, sa, sbs, pcs} = '0;
        alu = ALU_NOP;
        if (k == 0) begin
            mr = 1; irw = 1; pcen = 1; sbs = 2'd1; alu = ALU_ADD;
        end else if (k == 1) begin
            sbs = 2'd3; ext = 1; alu = ALU_ADD;
            if (kd == K_ILL) begin il = 1; dn = 1; end
        end else if (k == 2) begin
            case (kd)
                K_LW, K_SW: begin sa = 2'd1; sbs = 2'd2; ext = 1; alu = ALU_ADD; end
                K_R: begin
                    sa = (fn == 6'h00 || fn == 6'h02) ? 2'd2 : 2'd1;
                    case (fn)
                        6'h20: alu = ALU_ADD;  6'h21: alu = ALU_ADDU;
                        6'h22: alu = ALU_SUB;  6'h23: alu = ALU_SUBU;
                        6'h24: alu = ALU_AND;  6'h25: alu = ALU_OR;
                        6'h27: alu = ALU_NOR;  6'h2A: alu = ALU_SLT;
                        6'h2B: alu = ALU_SLTU;
                        6'h00, 6'h04: alu = ALU_SLL;
                        default: alu = ALU_SRL;
                    endcase
                end
                K_I: begin
                    sa = 2'd1; sbs = 2'd2;
                    case (op)
                        6'h08: begin alu = ALU_ADD;  ext = 1; end
                        6'h09: begin alu = ALU_ADDU; ext = 1; end
                        6'h0A: begin alu = ALU_SLT;  ext = 1; end
                        6'h0C: alu = ALU_AND;
                        6'h0D: alu = ALU_OR;
                        default: alu = ALU_LUI;
                    endcase
                end
                K_BR: begin
                    sa = 2'd1; alu = ALU_SUB; pcs = 2'd1; dn = 1;
                    pcen = (op == 6'h04) ? z : !z;
                end
                K_J:   begin pcen = 1; pcs = 2'd2; dn = 1; end
                K_JAL: begin pcen = 1; pcs = 2'd2; rw = 1; rd = 2'd2; m2r = 2'd2; dn = 1; end
                K_JR:  begin pcen = 1; pcs = 2'd3; dn = 1; end
                default: ;
            endcase
        end else if (k == 3) begin
            case (kd)
                K_LW: begin mr = 1; io = 1; end
                K_SW: begin mw = 1; io = 1; dn = 1; end
                K_R:  begin rw = 1; rd = 2'd1; dn = 1; end
                K_I:  begin rw = 1; dn = 1; end
                default: ;
            endcase
        end else if (k == 4) begin
            rw = 1; m2r = 2'd1; dn = 1;
        end
        return {pcen, io, mr, mw, irw, rw, rd, m2r, sa, sbs, ext, alu, pcs, dn, il};
    endfunction

    task automatic check(input string name, input logic [22:0] got, input logic [22:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: one scoreboard entry per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            if (act !== e.v) begin
                n_err++;
                $display("FAIL op=%h fn=%h cycle %0d: got %h expected %h",
                         e.op, e.fn, e.k, act, e.v);
            end
        end
    end

    // Called at posedge+1 while the DUT sits in FETCH; returns at the next FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zf);
        int n;
        n = cpi(classify(op, fn));
        for (int k = 0; k < n; k++) begin
            exp_t e;
            // IR contents are not valid in FETCH: drive junk to prove it is ignored.
            opcode = (k == 0) ? 6'($urandom_range(63)) : op;
            funct  = (k == 0) ? 6'($urandom_range(63)) : fn;
            zero   = (zf >= 0 && k == 2) ? zf[0] : 1'($urandom_range(1));
            e.v = exp_vec(op, fn, zero, k);
            e.op = op; e.fn = fn; e.k = k;
            sb_q.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    logic [5:0] ops [13] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C,
                             6'h0D, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] fns [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h04, 6'h06, 6'h08};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op, fn;
        rstn = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", act, '0);
        check("reset_state", {19'd0, state}, {19'd0, S_RST});
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        check("first_fetch_state", {19'd0, state}, {19'd0, S_FETCH});

        run_instr(6'h23, 6'h00, -1);
        run_instr(6'h04, 6'h11, 1);
        run_instr(6'h04, 6'h11, 0);
        run_instr(6'h05, 6'h11, 1);
        run_instr(6'h05, 6'h11, 0);
        run_instr(6'h00, 6'h00, -1);
        run_instr(6'h00, 6'h04, -1);
        run_instr(6'h0D, 6'h15, -1);
        run_instr(6'h0F, 6'h2A, -1);
        run_instr(6'h03, 6'h3C, -1);
        run_instr(6'h3F, 6'h00, -1);
        run_instr(6'h00, 6'h3F, -1);
        run_instr(6'h2B, 6'h01, -1);
        run_instr(6'h00, 6'h08, -1);
        run_instr(6'h02, 6'h07, -1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(7) == 0) begin
                op = 6'($urandom_range(63));
                fn = 6'($urandom_range(63));
            end else begin
                op = ops[$urandom_range(12)];
                fn = (op == 6'h00) ? fns[$urandom_range(13)] : 6'($urandom_range(63));
            end
            run_instr(op, fn, -1);
        end

        // Abandon an lw in MEM_RD with an asynchronous reset.
        opcode = 6'h3F; funct = 6'h3F;
        @(posedge clk); #1;
        opcode = 6'h23;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_lw_mem_rd", act, exp_vec(6'h23, 6'h00, 1'b0, 3));
        #2 rstn = 1'b0;
        #1;
        check("async_reset_outputs", act, '0);
        check("async_reset_state", {19'd0, state}, {19'd0, S_RST});
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        check("post_reset_fetch", act, exp_vec(6'h00, 6'h00, zero, 0));
        run_instr(6'h23, 6'h00, -1);
        run_instr(6'h00, 6'h02, -1);

        @(negedge clk); #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
